// File: rtl/herring_fpga_timer.sv
// Programmable 16-bit interval timer with prescaler, snapshot and open-drain IRQ,
// attached to the asynchronous 6502 bus through a two-stage input synchronizer.
module herring_fpga_timer #(
   parameter logic [7:0] ID_VALUE = 8'h48
) (
   input  logic       clk_src,
   input  logic       reset_n,
   input  logic       cpu_clk,
   input  logic       cs_n,
   input  logic       rw,
   input  logic [2:0] address,
   inout  wire  [7:0] data,
   output wire        irq_n
);

   logic        s1_phi2_q, s2_phi2_q, s1_cs_n_q, s2_cs_n_q, s1_rw_q, s2_rw_q;
   logic [2:0]  s1_addr_q, s2_addr_q;
   logic [7:0]  s1_data_q, s2_data_q;

   logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d, exp_q, exp_d, irq_q, irq_d;
   logic [7:0]  prescale_q, prescale_d, reload_lo_q, reload_lo_d;
   logic [7:0]  reload_hi_q, reload_hi_d, psc_q, psc_d;
   logic [15:0] count_q, count_d, snap_q, snap_d;
   logic        commit_s, wr_s, wr_hi_s, clr_exp_s, tick_s, expire_s;
   logic [7:0]  rd_data_s;

   // Two-stage synchronizer for every bus pin; idle bus is PHI2 low, deselected
   always_ff @(posedge clk_src or negedge reset_n) begin
      if (!reset_n) begin
         s1_phi2_q <= 1'b0;
         s2_phi2_q <= 1'b0;
         s1_cs_n_q <= 1'b1;
         s2_cs_n_q <= 1'b1;
         s1_rw_q   <= 1'b0;
         s2_rw_q   <= 1'b0;
         s1_addr_q <= 3'd0;
         s2_addr_q <= 3'd0;
         s1_data_q <= 8'd0;
         s2_data_q <= 8'd0;
      end else begin
         s1_phi2_q <= cpu_clk;
         s2_phi2_q <= s1_phi2_q;
         s1_cs_n_q <= cs_n;
         s2_cs_n_q <= s1_cs_n_q;
         s1_rw_q   <= rw;
         s2_rw_q   <= s1_rw_q;
         s1_addr_q <= address;
         s2_addr_q <= s1_addr_q;
         s1_data_q <= data;
         s2_data_q <= s1_data_q;
      end
   end

   // s2 still holds fields sampled while PHI2 was high when the fall is seen
   assign commit_s  = s2_phi2_q & ~s1_phi2_q;
   assign wr_s      = commit_s & ~s2_cs_n_q & ~s2_rw_q;
   assign wr_hi_s   = wr_s & (s2_addr_q == 3'd4);
   assign clr_exp_s = wr_s & (s2_addr_q == 3'd1) & s2_data_q[0];
   assign tick_s    = en_q & (psc_q == 8'd0) & ~wr_hi_s;
   assign expire_s  = tick_s & (count_q == 16'd0);
   assign exp_d     = expire_s | (exp_q & ~clr_exp_s);
   assign irq_d     = exp_d & ie_d;

   // Next-state for prescaler, counter and register writes
   always_comb begin
      en_d        = en_q;
      auto_d      = auto_q;
      ie_d        = ie_q;
      prescale_d  = prescale_q;
      reload_lo_d = reload_lo_q;
      reload_hi_d = reload_hi_q;
      snap_d      = snap_q;
      count_d     = count_q;
      psc_d       = psc_q;
      if (wr_hi_s) begin
         count_d = {s2_data_q, reload_lo_q};
         psc_d   = prescale_q;
      end else if (en_q) begin
         if (psc_q == 8'd0) begin
            psc_d = prescale_q;
         end else begin
            psc_d = psc_q - 8'd1;
         end
         if (!tick_s) begin
            count_d = count_q;
         end else if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
         end else if (auto_q) begin
            count_d = {reload_hi_q, reload_lo_q};
         end else begin
            en_d = 1'b0;
         end
      end else begin
         count_d = count_q;
         psc_d   = psc_q;
      end
      // A CTRL write lands after the expiry-driven EN clear, so software wins
      case ({wr_s, s2_addr_q})
         4'b1_000: begin
            en_d   = s2_data_q[0];
            auto_d = s2_data_q[1];
            ie_d   = s2_data_q[2];
         end
         4'b1_010: prescale_d  = s2_data_q;
         4'b1_011: reload_lo_d = s2_data_q;
         4'b1_100: reload_hi_d = s2_data_q;
         4'b1_111: snap_d      = count_q;
         default:  snap_d      = snap_q;
      endcase
   end

   // Timer state registers
   always_ff @(posedge clk_src or negedge reset_n) begin
      if (!reset_n) begin
         en_q        <= 1'b0;
         auto_q      <= 1'b0;
         ie_q        <= 1'b0;
         exp_q       <= 1'b0;
         irq_q       <= 1'b0;
         prescale_q  <= 8'd0;
         reload_lo_q <= 8'd0;
         reload_hi_q <= 8'd0;
         psc_q       <= 8'd0;
         count_q     <= 16'd0;
         snap_q      <= 16'd0;
      end else begin
         en_q        <= en_d;
         auto_q      <= auto_d;
         ie_q        <= ie_d;
         exp_q       <= exp_d;
         irq_q       <= irq_d;
         prescale_q  <= prescale_d;
         reload_lo_q <= reload_lo_d;
         reload_hi_q <= reload_hi_d;
         psc_q       <= psc_d;
         count_q     <= count_d;
         snap_q      <= snap_d;
      end
   end

   // Read mux, fed only from registers
   always_comb begin
      case (address)
         3'd0:    rd_data_s = {5'd0, ie_q, auto_q, en_q};
         3'd1:    rd_data_s = {7'd0, exp_q};
         3'd2:    rd_data_s = prescale_q;
         3'd3:    rd_data_s = reload_lo_q;
         3'd4:    rd_data_s = reload_hi_q;
         3'd5:    rd_data_s = snap_q[7:0];
         3'd6:    rd_data_s = snap_q[15:8];
         default: rd_data_s = ID_VALUE;
      endcase
   end

   assign data  = (~cs_n & rw & cpu_clk) ? rd_data_s : 8'hzz;
   assign irq_n = irq_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_herring_fpga_timer.sv
// Randomized bench for herring_fpga_timer: bus cycles are driven on clk_src
// negedges and every cycle is compared against a behavioural timer model.
module tb_herring_fpga_timer;

   logic       clk_src = 1'b0;
   logic       reset_n = 1'b0;
   logic       cpu_clk = 1'b0;
   logic       cs_n    = 1'b1;
   logic       rw      = 1'b1;
   logic [2:0] address = 3'd0;
   logic [7:0] tb_dout = 8'd0;
   wire  [7:0] data;
   wire        irq_n;

   pullup pu_data (data);
   pullup pu_irq (irq_n);
   assign data = (!rw) ? tb_dout : 8'hzz;

   herring_fpga_timer #(.ID_VALUE(8'h48)) dut (
      .clk_src (clk_src),
      .reset_n (reset_n),
      .cpu_clk (cpu_clk),
      .cs_n    (cs_n),
      .rw      (rw),
      .address (address),
      .data    (data),
      .irq_n   (irq_n)
   );

   always #10 clk_src = ~clk_src;

   int n_chk  = 0;
   int n_pass = 0;
   int cycle_no = 0;

   // Reference model of the programmer-visible timer
   bit          m_en, m_auto, m_ie, m_exp;
   logic [7:0]  m_pre, m_rlo, m_rhi, m_psc;
   logic [15:0] m_cnt, m_snap;
   int          commit_cnt;
   logic        cm_cs, cm_rw;
   logic [2:0]  cm_a;
   logic [7:0]  cm_d;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_chk++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cycle_no);
   endtask

   task automatic m_reset();
      m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
      m_pre = 8'd0; m_rlo = 8'd0; m_rhi = 8'd0; m_psc = 8'd0;
      m_cnt = 16'd0; m_snap = 16'd0; commit_cnt = 0;
   endtask

   function automatic logic [7:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {5'd0, m_ie, m_auto, m_en};
         3'd1:    return {7'd0, m_exp};
         3'd2:    return m_pre;
         3'd3:    return m_rlo;
         3'd4:    return m_rhi;
         3'd5:    return m_snap[7:0];
         3'd6:    return m_snap[15:8];
         default: return 8'h48;
      endcase
   endfunction

   // One clk_src period of the timer, with an optional committed bus write
   task automatic m_clock(input bit wr, input logic [2:0] a, input logic [7:0] d);
      bit          restart, tick, expired, en_n;
      logic [15:0] cnt_n, reload;
      logic [7:0]  psc_n;
      reload  = {m_rhi, m_rlo};
      restart = wr && (a == 3'd4);
      tick    = m_en && (m_psc == 8'd0) && !restart;
      expired = tick && (m_cnt == 16'd0);
      en_n    = m_en;
      cnt_n   = m_cnt;
      psc_n   = m_psc;
      if (restart) begin
         cnt_n = {d, m_rlo};
         psc_n = m_pre;
      end else if (m_en) begin
         psc_n = tick ? m_pre : m_psc - 8'd1;
      end
      if (tick && !expired) cnt_n = m_cnt - 16'd1;
      if (expired && m_auto) cnt_n = reload;
      if (expired && !m_auto) en_n = 0;
      if (wr) begin
         case (a)
            3'd0: begin en_n = d[0]; m_auto = d[1]; m_ie = d[2]; end
            3'd1: if (d[0]) m_exp = 0;
            3'd2: m_pre = d;
            3'd3: m_rlo = d;
            3'd4: m_rhi = d;
            3'd7: m_snap = m_cnt;
            default: ;
         endcase
      end
      if (expired) m_exp = 1;
      m_en  = en_n;
      m_cnt = cnt_n;
      m_psc = psc_n;
   endtask

   // Drive the pins for one cycle, step the model, then check irq_n and data
   task automatic cyc(input logic ph, c, r, input logic [2:0] a, input logic [7:0] d);
      bit         commit;
      logic [7:0] exp_bus;
      @(negedge clk_src);
      if (cpu_clk && !ph && reset_n) begin
         commit_cnt = 2;
         cm_cs = cs_n; cm_rw = rw; cm_a = address; cm_d = tb_dout;
      end
      cpu_clk = ph; cs_n = c; rw = r; address = a; tb_dout = d;
      @(posedge clk_src);
      commit = (commit_cnt == 1);
      if (commit_cnt > 0) commit_cnt--;
      m_clock(commit && !cm_cs && !cm_rw, cm_a, cm_d);
      cycle_no++;
      #1;
      chk("irq", {15'd0, irq_n}, (m_exp && m_ie) ? 16'd0 : 16'd1);
      if (!rw) exp_bus = tb_dout;
      else if (!cs_n && cpu_clk) exp_bus = m_read(address);
      else exp_bus = 8'hFF;
      chk("data", {8'd0, data}, {8'd0, exp_bus});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'd0);
   endtask

   task automatic bus(input logic c, r, input logic [2:0] a, input logic [7:0] d,
                      output logic [7:0] rd);
      cyc(1'b0, c, r, a, d);
      for (int i = 0; i < 3; i++) cyc(1'b1, c, r, a, d);
      rd = data;
      cyc(1'b0, c, r, a, d);
      cyc(1'b0, c, r, a, d);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      logic [7:0] dummy;
      bus(1'b0, 1'b0, a, d, dummy);
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] v);
      bus(1'b0, 1'b1, a, 8'd0, v);
   endtask

   task automatic wait_irq(input int bound, output int at);
      int n = 0;
      while (n < bound && irq_n !== 1'b0) begin
         idle(1);
         n++;
      end
      if (irq_n !== 1'b0) chk("irq_wait", {15'd0, irq_n}, 16'd0);
      at = cycle_no;
   endtask

   task automatic do_reset();
      @(negedge clk_src);
      reset_n = 1'b0; cpu_clk = 1'b0; cs_n = 1'b1; rw = 1'b1; address = 3'd0; tb_dout = 8'd0;
      m_reset();
      #1;
      chk("rst_irq", {15'd0, irq_n}, 16'd1);
      chk("rst_data", {8'd0, data}, 16'h00FF);
      repeat (3) @(posedge clk_src);
      @(negedge clk_src);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [7:0] v;
      int t0, t1, a, b;
      m_reset();
      do_reset();

      // reset values of every register
      for (int r = 0; r < 7; r++) begin
         rd(r[2:0], v);
         chk("rst_reg", {8'd0, v}, 16'd0);
      end
      rd(3'd7, v);
      chk("id", {8'd0, v}, 16'h0048);

      // one-shot: (3+1)*(4+1) = 20 cycles from enabling
      wr(3'd2, 8'd4); wr(3'd3, 8'd3); wr(3'd4, 8'd0); wr(3'd0, 8'h05);
      t0 = cycle_no;
      wait_irq(60, t1);
      chk("oneshot_lat", t1[15:0] - t0[15:0], 16'd20);
      rd(3'd0, v); chk("oneshot_en", {8'd0, v}, 16'h0004);
      rd(3'd1, v); chk("oneshot_exp", {8'd0, v}, 16'h0001);
      wr(3'd7, 8'd0);
      rd(3'd5, v); chk("oneshot_cnt_lo", {8'd0, v}, 16'd0);
      rd(3'd6, v); chk("oneshot_cnt_hi", {8'd0, v}, 16'd0);
      wr(3'd1, 8'h01);
      chk("irq_cleared", {15'd0, irq_n}, 16'd1);

      // auto-reload every 10 cycles
      wr(3'd2, 8'd0); wr(3'd3, 8'd9); wr(3'd4, 8'd0); wr(3'd0, 8'h07);
      wait_irq(40, a);
      for (int k = 0; k < 3; k++) begin
         wr(3'd1, 8'h01);
         wait_irq(40, b);
         chk("auto_period", b[15:0] - a[15:0], 16'd10);
         a = b;
      end

      // clear race: STATUS clear commits on the expiry edge (period 20)
      wr(3'd0, 8'h00); wr(3'd2, 8'd1); wr(3'd3, 8'd9); wr(3'd4, 8'd0);
      wr(3'd1, 8'h01); wr(3'd0, 8'h07);
      wait_irq(60, a);
      wr(3'd1, 8'h01);
      idle(8);
      wr(3'd1, 8'h01);
      chk("race_irq", {15'd0, irq_n}, 16'd0);
      rd(3'd1, v); chk("race_exp", {8'd0, v}, 16'h0001);

      // snapshot of 0x1234 while counting carries on
      wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'hFF);
      wr(3'd3, 8'h34); wr(3'd4, 8'h12); wr(3'd7, 8'h00); wr(3'd0, 8'h01);
      rd(3'd5, v); chk("snap_lo", {8'd0, v}, 16'h0034);
      rd(3'd6, v); chk("snap_hi", {8'd0, v}, 16'h0012);
      rd(3'd7, v); chk("snap_id", {8'd0, v}, 16'h0048);

      // bus gating: deselected write, read with PHI2 low
      wr(3'd0, 8'h00); wr(3'd2, 8'h11);
      bus(1'b1, 1'b0, 3'd2, 8'hAA, v);
      rd(3'd2, v); chk("gate_wr", {8'd0, v}, 16'h0011);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 3'd7, 8'd0);
         chk("gate_z", {8'd0, data}, 16'h00FF);
      end

      // reset during a running timer and an in-flight write
      wr(3'd2, 8'd0); wr(3'd3, 8'd5); wr(3'd4, 8'd0); wr(3'd0, 8'h07);
      idle(7);
      cyc(1'b0, 1'b0, 1'b0, 3'd2, 8'h55);
      cyc(1'b1, 1'b0, 1'b0, 3'd2, 8'h55);
      cyc(1'b1, 1'b0, 1'b0, 3'd2, 8'h55);
      do_reset();
      rd(3'd2, v); chk("rst_lost_wr", {8'd0, v}, 16'd0);
      rd(3'd0, v); chk("rst_ctrl", {8'd0, v}, 16'd0);

      // randomized bus traffic against the model
      for (int n = 0; n < 250; n++) begin
         int         op;
         logic [2:0] ra;
         logic [7:0] rdat;
         op   = $urandom_range(0, 9);
         ra   = 3'($urandom_range(0, 7));
         rdat = 8'($urandom_range(0, 255));
         if (ra == 3'd4) rdat = 8'($urandom_range(0, 1));
         if (ra == 3'd3) rdat = 8'($urandom_range(0, 12));
         if (ra == 3'd2) rdat = 8'($urandom_range(0, 3));
         if (op < 2) idle($urandom_range(1, 8));
         else bus(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ra, rdat, v);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
